mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single SAYEH data/instruction memory between the CPU controller port and one DMA requester. CPU reads use the controller's level-held `ReadMem` / `memDataReady` handshake. CPU writes are single-cycle `WriteMem` pulses and are absorbed by a one-entry posted-write buffer. The block sits between the controller/datapath address bus and the memory, and owns all `mem_*` strobes and wait-state timing.

## Interface
- `ADDR_W`, 16, address width.
- `DATA_W`, 16, data width.
- `WAIT_CYCLES`, 2, memory access cycles per transfer (legal 1..15).
- `clk` in 1 — system clock, rising edge.
- `ExternalReset` in 1 — asynchronous, active-high reset.
- `cpu_read` in 1 — CPU read request (`ReadMem`); held high until `memDataReady`.
- `cpu_write` in 1 — CPU write pulse (`WriteMem`); one cycle.
- `cpu_addr` in ADDR_W — CPU address.
- `cpu_wdata` in DATA_W — CPU write data.
- `cpu_rdata` out DATA_W — CPU read data; valid while `memDataReady`=1.
- `memDataReady` out 1 — one-cycle CPU read completion.
- `dma_req` in 1 — DMA request; level, held until `dma_ack`.
- `dma_we` in 1 — DMA write (1) / read (0); stable with `dma_req`.
- `dma_addr` in ADDR_W — DMA address.
- `dma_wdata` in DATA_W — DMA write data.
- `dma_rdata` out DATA_W — DMA read data; valid while `dma_ack`=1.
- `dma_ack` out 1 — one-cycle DMA completion (reads and writes).
- `mem_addr` out ADDR_W — memory address.
- `mem_wdata` out DATA_W — memory write data.
- `mem_rd` out 1 — memory read strobe.
- `mem_wr` out 1 — memory write strobe.
- `mem_rdata` in DATA_W — memory read data; sampled on the last ACCESS cycle.
- `grant_dma` out 1 — high while DMA owns the current transfer.
- `wr_overflow` out 1 — sticky; a CPU write was dropped.

## Operation
- States: IDLE, ACCESS, DONE, GAP.
- IDLE, arbitration among candidates:
  - CPU candidate = `wbuf_valid` or `cpu_read`.
  - DMA candidate = `dma_req`.
  - Winner latches address, data and direction, then goes to ACCESS.
  - No candidate: stay in IDLE.
- Within the CPU port, a pending `wbuf` drains before `cpu_read`. This guarantees read-after-write ordering.
- ACCESS:
  - `mem_rd` or `mem_wr` is held for WAIT_CYCLES cycles, with `mem_addr`/`mem_wdata` stable.
  - Internal counter runs 0..WAIT_CYCLES-1.
  - Read data is registered on the last ACCESS cycle.
  - Then go to DONE.
- DONE, one cycle:
  - CPU read: `memDataReady`=1 with `cpu_rdata`.
  - DMA transfer: `dma_ack`=1, plus `dma_rdata` on reads.
  - wbuf drain: no ack; `wbuf_valid` clears.
  - Then go to GAP.
- GAP, one cycle: no arbitration. This lets the served requester drop its registered request line, so a stale level cannot re-trigger. Then go to IDLE.
- Posted write buffer (`wbuf`):
  - When empty, `cpu_write` captures `cpu_addr`/`cpu_wdata` in any state.
  - `cpu_write` while full: the write is dropped and `wr_overflow` sets. It clears only on reset.
  - `cpu_write` in the same cycle the buffer drains (DONE): the buffer counts as full and the write is dropped.
- Simultaneous CPU and DMA candidates in IDLE are resolved per Configuration.
- Reset (asynchronous, any state):
  - State returns to IDLE; counter and `wbuf` are cleared.
  - All outputs go to 0 immediately, including strobes in mid-ACCESS.
  - An in-flight transfer is abandoned with no ack.

## Timing
- Reset values: `cpu_rdata`=0, `memDataReady`=0, `dma_rdata`=0, `dma_ack`=0, `mem_addr`=0, `mem_wdata`=0, `mem_rd`=0, `mem_wr`=0, `grant_dma`=0, `wr_overflow`=0.
- All outputs are registered.
- Request sampled in IDLE at edge 0:
  - ACCESS strobes are high for cycles 1..W.
  - Ack is high in cycle W+1.
  - GAP is cycle W+2.
  - Next arbitration happens at edge W+3.
- Request-to-ack latency = WAIT_CYCLES+1 cycles.
- Back-to-back throughput is one transfer per WAIT_CYCLES+3 cycles.
- `grant_dma` is valid from the first ACCESS cycle through GAP.
- A request deasserted before being granted is simply not served.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. On contention, the port not served most recently wins. The last-served flag resets to DMA, so the CPU wins the first contention.
- `MEM_ARB_RR_EN` undefined: fixed priority. The CPU always wins and DMA is served only when the CPU port is idle.

## Test plan
- CPU read with WAIT_CYCLES=2, `cpu_addr`=0x0010, memory returns 0xBEEF:
  - `mem_rd` high 2 cycles.
  - `memDataReady` pulses 1 cycle with `cpu_rdata`=0xBEEF, 3 cycles after request.
  - No second read while `cpu_read` lingers during GAP.
- CPU write pulse 0x0020←0x1234 while a DMA read is in ACCESS:
  - Buffered; `mem_wr` with addr 0x0020 / data 0x1234 starts after the DMA's GAP.
  - A subsequent `cpu_read` of 0x0020 returns 0x1234.
- `cpu_read` and `dma_req` asserted together, continuously:
  - Fixed priority: CPU served every time.
  - With `MEM_ARB_RR_EN`: grants alternate CPU, DMA, CPU, DMA.
- Second `cpu_write` while `wbuf` is full: `wr_overflow`=1, the first write completes, the second never reaches memory.
- DMA write 0x0100←0x00FF: `mem_wr` held WAIT_CYCLES cycles, then `dma_ack` for 1 cycle with `grant_dma`=1.
- `ExternalReset` asserted mid-ACCESS:
  - `mem_rd`/`mem_wr` drop to 0 without waiting for a clock edge.
  - No ack is issued and `wbuf` is emptied.
  - After release, a new request is served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single SAYEH data/instruction memory between the CPU controller
// port and one DMA requester. CPU reads follow the controller's level-held
// ReadMem / memDataReady handshake. CPU writes are one-cycle WriteMem pulses
// absorbed by a one-entry posted-write buffer (wbuf). The block owns every
// mem_* strobe and the wait-state timing.
//
// Each transfer runs IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE -> GAP.
// The GAP cycle lets a served requester drop its registered request line so
// a stale level cannot start a second transfer.
//
// Ports:
//   clk, ExternalReset          clock (rising edge), async active-high reset
//   cpu_read, cpu_addr          CPU read request (level, held to memDataReady)
//   cpu_write, cpu_wdata        CPU write pulse, captured by the write buffer
//   cpu_rdata, memDataReady     CPU read data and one-cycle completion
//   dma_req, dma_we             DMA request (level, held to dma_ack), direction
//   dma_addr, dma_wdata         DMA address and write data
//   dma_rdata, dma_ack          DMA read data and one-cycle completion
//   mem_addr, mem_wdata         memory address / write data
//   mem_rd, mem_wr, mem_rdata   memory strobes and read data
//   grant_dma                   DMA owns the current transfer (ACCESS..GAP)
//   wr_overflow                 sticky: a CPU write was dropped
//
// Build option:
//   MEM_ARB_RR_EN  defined   -> round-robin between CPU and DMA on contention
//                  undefined -> fixed priority, CPU always wins
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = 2     // legal 1..15
) (
   input  logic              clk,
   input  logic              ExternalReset,
   // CPU port
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              memDataReady,
   // DMA port
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_ack,
   // memory port
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_rdata,
   // status
   output logic              grant_dma,
   output logic              wr_overflow
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE, GAP} state_t;

   localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

   state_t            state;
   logic [3:0]        waitCnt;
   logic              curDma;     // transfer belongs to the DMA port
   logic              curWrite;   // transfer is a write
   logic              curDrain;   // transfer is a write-buffer drain

   logic              wbufValid;
   logic [ADDR_W-1:0] wbufAddr;
   logic [DATA_W-1:0] wbufData;

   logic              cpuCand;
   logic              pickDma;
   logic              drainDone;

`ifdef MEM_ARB_RR_EN
   logic              lastDma;    // most recently served port was DMA
`endif

   // ---------------------------------------------------------------------------
   // Arbitration (only consumed in IDLE)
   // ---------------------------------------------------------------------------
   // NOTE: every variable assigned in always_comb gets a value on every path,
   // otherwise synthesis infers a latch.
   always_comb begin
      cpuCand = wbufValid | cpu_read;
`ifdef MEM_ARB_RR_EN
      // On contention the port not served most recently wins.
      pickDma = dma_req & (~cpuCand | ~lastDma);
`else
      pickDma = dma_req & ~cpuCand;
`endif
      drainDone = (state == DONE) & curDrain;
   end

   // ---------------------------------------------------------------------------
   // Transfer FSM with registered outputs
   // ---------------------------------------------------------------------------
   // NOTE: the asynchronous reset clears the registered strobes directly, so
   // mem_rd/mem_wr fall as soon as ExternalReset rises, even mid-ACCESS.
   always_ff @(posedge clk or posedge ExternalReset) begin
      if (ExternalReset) begin
         state        <= IDLE;
         waitCnt      <= '0;
         curDma       <= 1'b0;
         curWrite     <= 1'b0;
         curDrain     <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_rd       <= 1'b0;
         mem_wr       <= 1'b0;
         grant_dma    <= 1'b0;
         cpu_rdata    <= '0;
         memDataReady <= 1'b0;
         dma_rdata    <= '0;
         dma_ack      <= 1'b0;
`ifdef MEM_ARB_RR_EN
         lastDma      <= 1'b1;   // CPU wins the first contention
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments only; the
         // completion pulses default low and are raised for exactly one cycle.
         memDataReady <= 1'b0;
         dma_ack      <= 1'b0;

         case (state)
            IDLE: begin
               waitCnt <= '0;
               if (pickDma) begin
                  mem_addr  <= dma_addr;
                  mem_wdata <= dma_wdata;
                  mem_rd    <= ~dma_we;
                  mem_wr    <= dma_we;
                  grant_dma <= 1'b1;
                  curDma    <= 1'b1;
                  curWrite  <= dma_we;
                  curDrain  <= 1'b0;
`ifdef MEM_ARB_RR_EN
                  lastDma   <= 1'b1;
`endif
                  state     <= ACCESS;
               end else if (cpuCand) begin
                  grant_dma <= 1'b0;
                  curDma    <= 1'b0;
`ifdef MEM_ARB_RR_EN
                  lastDma   <= 1'b0;
`endif
                  // A pending posted write drains before any CPU read, which
                  // keeps read-after-write ordering on the CPU port.
                  if (wbufValid) begin
                     mem_addr  <= wbufAddr;
                     mem_wdata <= wbufData;
                     mem_rd    <= 1'b0;
                     mem_wr    <= 1'b1;
                     curWrite  <= 1'b1;
                     curDrain  <= 1'b1;
                  end else begin
                     mem_addr  <= cpu_addr;
                     mem_rd    <= 1'b1;
                     mem_wr    <= 1'b0;
                     curWrite  <= 1'b0;
                     curDrain  <= 1'b0;
                  end
                  state <= ACCESS;
               end
            end

            ACCESS: begin
               if (waitCnt == LAST_CNT) begin
                  // Last access cycle: sample read data and raise the ack.
                  mem_rd <= 1'b0;
                  mem_wr <= 1'b0;
                  if (curDma) begin
                     dma_ack <= 1'b1;
                     if (!curWrite) begin
                        dma_rdata <= mem_rdata;
                     end
                  end else if (!curDrain) begin
                     memDataReady <= 1'b1;
                     cpu_rdata    <= mem_rdata;
                  end
                  state <= DONE;
               end else begin
                  waitCnt <= waitCnt + 4'd1;
               end
            end

            DONE: begin
               state <= GAP;
            end

            GAP: begin
               grant_dma <= 1'b0;
               state     <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // One-entry posted-write buffer
   // ---------------------------------------------------------------------------
   // A write arriving in the drain's DONE cycle still sees the buffer full and
   // is dropped, because wbufValid only clears at the end of that cycle.
   always_ff @(posedge clk or posedge ExternalReset) begin
      if (ExternalReset) begin
         wbufValid   <= 1'b0;
         wbufAddr    <= '0;
         wbufData    <= '0;
         wr_overflow <= 1'b0;
      end else begin
         if (drainDone) begin
            wbufValid <= 1'b0;
         end
         if (cpu_write) begin
            if (wbufValid) begin
               wr_overflow <= 1'b1;
            end else begin
               wbufValid <= 1'b1;
               wbufAddr  <= cpu_addr;
               wbufData  <= cpu_wdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter with WAIT_CYCLES=2. A small memory model sits
// on the mem_* port. Single transfers come from a table of records holding the
// request and the expected strobe timing / data; multi-cycle corner cases
// (contention, lingering read, write behind DMA, overflow, drain-cycle write,
// reset mid-ACCESS) are hand-written sequences. Inputs change on the falling
// edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        ExternalReset;
   logic        cpu_read, cpu_write;
   logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        memDataReady;
   logic        dma_req, dma_we;
   logic [15:0] dma_addr, dma_wdata, dma_rdata;
   logic        dma_ack;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_rd, mem_wr;
   logic        grant_dma, wr_overflow;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(W)) dut (
      .clk(clk), .ExternalReset(ExternalReset),
      .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .memDataReady(memDataReady),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd),
      .mem_wr(mem_wr), .mem_rdata(mem_rdata),
      .grant_dma(grant_dma), .wr_overflow(wr_overflow)
   );

   // ---------------------------------------------------------------------------
   // Memory model and activity counters (sampled on the rising edge, before
   // the DUT's registers update)
   // ---------------------------------------------------------------------------
   logic [15:0] memArr [0:4095];
   int rdCycles = 0;
   int wrCycles = 0;
   int ackCount = 0;

   assign mem_rdata = mem_rd ? memArr[mem_addr[11:0]] : 16'hDEAD;

   always @(posedge clk) begin
      if (mem_wr) memArr[mem_addr[11:0]] = mem_wdata;
      if (mem_rd) rdCycles++;
      if (mem_wr) wrCycles++;
      if (memDataReady || dma_ack) ackCount++;
   end

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   typedef enum logic [1:0] {K_CPU_RD, K_CPU_WR, K_DMA_RD, K_DMA_WR} kind_t;

   typedef struct {
      kind_t       kind;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] expData;   // expected read data (reads only)
      int          expFirst;  // cycle of first strobe after the request
      int          expAck;    // cycle of the ack, 0 = no ack expected
   } vec_t;

   // Issues one isolated transfer from IDLE and checks its full timeline.
   task automatic runVec(input vec_t v, input string tag);
      int          strobeCnt   = 0;
      int          firstStrobe = 0;
      int          ackCyc      = 0;
      logic [15:0] sAddr = '0, sData = '0, aData = '0;
      logic        sWr = 1'b0, sGrant = 1'b0, aGrant = 1'b0, aIsDma = 1'b0;
      logic        isDma = (v.kind == K_DMA_RD) || (v.kind == K_DMA_WR);
      logic        isWr  = (v.kind == K_CPU_WR) || (v.kind == K_DMA_WR);

      case (v.kind)
         K_CPU_RD: begin cpu_read = 1'b1; cpu_addr = v.addr; end
         K_CPU_WR: begin cpu_write = 1'b1; cpu_addr = v.addr; cpu_wdata = v.wdata; end
         default: begin
            dma_req = 1'b1; dma_we = isWr; dma_addr = v.addr; dma_wdata = v.wdata;
         end
      endcase

      for (int cyc = 1; cyc <= 12; cyc++) begin
         tick();
         if (cyc == 1) cpu_write = 1'b0;
         if (mem_rd || mem_wr) begin
            strobeCnt++;
            if (firstStrobe == 0) begin
               firstStrobe = cyc;
               sAddr  = mem_addr;
               sData  = mem_wdata;
               sWr    = mem_wr;
               sGrant = grant_dma;
            end
         end
         if ((memDataReady || dma_ack) && ackCyc == 0) begin
            ackCyc = cyc;
            aIsDma = dma_ack;
            aData  = dma_ack ? dma_rdata : cpu_rdata;
            aGrant = grant_dma;
            cpu_read = 1'b0;
            dma_req  = 1'b0;
         end
      end
      cpu_read = 1'b0;
      dma_req  = 1'b0;

      check({tag, "_firstStrobe"}, firstStrobe, v.expFirst);
      check({tag, "_strobeCycles"}, strobeCnt, W);
      check({tag, "_memAddr"}, sAddr, v.addr);
      check({tag, "_isWrite"}, sWr, isWr);
      check({tag, "_grantInAccess"}, sGrant, isDma);
      check({tag, "_ackCycle"}, ackCyc, v.expAck);
      if (isWr) begin
         check({tag, "_memWdata"}, sData, v.wdata);
         check({tag, "_memContent"}, memArr[v.addr[11:0]], v.wdata);
      end
      if (v.expAck != 0) begin
         check({tag, "_ackPort"}, aIsDma, isDma);
         check({tag, "_grantInDone"}, aGrant, isDma);
         if (!isWr) check({tag, "_rdata"}, aData, v.expData);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------------------
   vec_t vecs [8];
   vec_t extra;
   logic [3:0] expGrants;
   logic [3:0] gotGrants;
   int nAck, rdBase, wrBase, ackBase;

   initial begin
      vecs[0] = '{K_DMA_WR, 16'h0100, 16'h00FF, 16'h0000, 1, W + 1};
      vecs[1] = '{K_CPU_RD, 16'h0100, 16'h0000, 16'h00FF, 1, W + 1};
      vecs[2] = '{K_CPU_WR, 16'h0040, 16'hA5A5, 16'h0000, 2, 0};
      vecs[3] = '{K_DMA_RD, 16'h0040, 16'h0000, 16'hA5A5, 1, W + 1};
      vecs[4] = '{K_CPU_RD, 16'h0010, 16'h0000, 16'hBEEF, 1, W + 1};
      vecs[5] = '{K_DMA_RD, 16'h0030, 16'h0000, 16'h3333, 1, W + 1};
      vecs[6] = '{K_CPU_WR, 16'h0000, 16'hFFFF, 16'h0000, 2, 0};
      vecs[7] = '{K_CPU_RD, 16'h0000, 16'h0000, 16'hFFFF, 1, W + 1};

`ifdef MEM_ARB_RR_EN
      expGrants = 4'b1010;   // CPU, DMA, CPU, DMA (bit 0 first)
`else
      expGrants = 4'b0000;   // CPU every time
`endif

      for (int i = 0; i < 4096; i++) memArr[i] = 16'h0000;
      memArr[12'h010] = 16'hBEEF;
      memArr[12'h030] = 16'h3333;
      memArr[12'h060] = 16'h0BAD;
      memArr[12'h080] = 16'h0808;
      memArr[12'h090] = 16'h0909;

      ExternalReset = 1'b1;
      cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;

      // --- reset values ---
      tick(3);
      check("rst_cpu_rdata", cpu_rdata, 0);
      check("rst_memDataReady", memDataReady, 0);
      check("rst_dma_rdata", dma_rdata, 0);
      check("rst_dma_ack", dma_ack, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_mem_rd", mem_rd, 0);
      check("rst_mem_wr", mem_wr, 0);
      check("rst_grant_dma", grant_dma, 0);
      check("rst_wr_overflow", wr_overflow, 0);
      ExternalReset = 1'b0;
      tick(2);

      // --- continuous contention right after reset ---
      cpu_read = 1'b1; cpu_addr = 16'h0010;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0030;
      nAck = 0;
      gotGrants = '0;
      for (int cyc = 0; cyc < 60 && nAck < 4; cyc++) begin
         tick();
         if (memDataReady || dma_ack) begin
            gotGrants[nAck] = grant_dma;
            check("cont_ackMatchesGrant", dma_ack, grant_dma);
            check("cont_rdata", dma_ack ? dma_rdata : cpu_rdata,
                  grant_dma ? 16'h3333 : 16'hBEEF);
            nAck++;
         end
      end
      cpu_read = 1'b0; dma_req = 1'b0;
      check("cont_acksSeen", nAck, 4);
      for (int i = 0; i < 4; i++) check($sformatf("cont_grant%0d", i), gotGrants[i], expGrants[i]);
      tick(8);

      // --- table of isolated transfers ---
      for (int i = 0; i < 8; i++) runVec(vecs[i], $sformatf("vec%0d", i));

      // --- CPU read with cpu_read lingering through GAP ---
      rdBase = rdCycles;
      cpu_read = 1'b1; cpu_addr = 16'h0010;
      tick(W);
      check("linger_noEarlyReady", memDataReady, 0);
      tick();
      check("linger_ready", memDataReady, 1);
      check("linger_rdata", cpu_rdata, 16'hBEEF);
      tick();   // GAP: request still high
      check("linger_readyOneCycle", memDataReady, 0);
      cpu_read = 1'b0;
      tick(6);
      check("linger_singleRead", rdCycles - rdBase, W);

      // --- CPU write posted while a DMA read is in ACCESS ---
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0030;
      for (int cyc = 1; cyc <= W + 4; cyc++) begin
         tick();
         if (cyc == 1) begin
            check("post_dmaAccess", mem_rd, 1);
            cpu_write = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
         end
         if (cyc == 2) cpu_write = 1'b0;
         if (cyc == W + 1) begin
            check("post_dmaAck", dma_ack, 1);
            check("post_dmaRdata", dma_rdata, 16'h3333);
            dma_req = 1'b0;
         end
         if (cyc == W + 3) check("post_noWrBeforeIdle", mem_wr, 0);
         if (cyc == W + 4) begin
            check("post_wrStarts", mem_wr, 1);
            check("post_wrAddr", mem_addr, 16'h0020);
            check("post_wrData", mem_wdata, 16'h1234);
            check("post_wrGrant", grant_dma, 0);
         end
      end
      tick(8);
      extra = '{K_CPU_RD, 16'h0020, 16'h0000, 16'h1234, 1, W + 1};
      runVec(extra, "rdAfterWr");

      // --- second write while the buffer is full ---
      check("ovf_clearBefore", wr_overflow, 0);
      cpu_write = 1'b1; cpu_addr = 16'h0050; cpu_wdata = 16'h5555;
      tick();
      cpu_addr = 16'h0060; cpu_wdata = 16'h6666;
      tick();
      cpu_write = 1'b0;
      check("ovf_set", wr_overflow, 1);
      tick(10);
      check("ovf_firstWritten", memArr[12'h050], 16'h5555);
      check("ovf_secondDropped", memArr[12'h060], 16'h0BAD);
      check("ovf_sticky", wr_overflow, 1);

      // --- write arriving in the drain's DONE cycle is dropped ---
      cpu_write = 1'b1; cpu_addr = 16'h0070; cpu_wdata = 16'h7777;
      for (int cyc = 1; cyc <= W + 3; cyc++) begin
         tick();
         if (cyc == 1) cpu_write = 1'b0;
         if (cyc == W + 1) check("drain_lastAccess", mem_wr, 1);
         if (cyc == W + 2) begin
            check("drain_doneNoStrobe", mem_wr, 0);
            cpu_write = 1'b1; cpu_addr = 16'h0080; cpu_wdata = 16'h8888;
         end
         if (cyc == W + 3) cpu_write = 1'b0;
      end
      tick(10);
      check("drain_firstWritten", memArr[12'h070], 16'h7777);
      check("drain_doneWriteDropped", memArr[12'h080], 16'h0808);

      // --- reset in the middle of ACCESS with a posted write pending ---
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0010;
      tick();
      check("rstmid_accessActive", mem_rd, 1);
      cpu_write = 1'b1; cpu_addr = 16'h0090; cpu_wdata = 16'h1111;
      tick();
      cpu_write = 1'b0;
      ExternalReset = 1'b1;
      #1;
      check("rstmid_rdDropsAsync", mem_rd, 0);
      check("rstmid_wrLow", mem_wr, 0);
      check("rstmid_grantLow", grant_dma, 0);
      check("rstmid_addrCleared", mem_addr, 0);
      dma_req = 1'b0;
      ackBase = ackCount;
      wrBase  = wrCycles;
      tick(2);
      ExternalReset = 1'b0;
      check("rstmid_overflowCleared", wr_overflow, 0);
      tick(10);
      check("rstmid_noAck", ackCount - ackBase, 0);
      check("rstmid_noWrite", wrCycles - wrBase, 0);
      check("rstmid_wbufEmptied", memArr[12'h090], 16'h0909);
      extra = '{K_DMA_WR, 16'h0200, 16'h2222, 16'h0000, 1, W + 1};
      runVec(extra, "afterRstWr");
      extra = '{K_CPU_RD, 16'h0200, 16'h0000, 16'h2222, 1, W + 1};
      runVec(extra, "afterRstRd");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
